inverse_transmission_srsc: RTL and testbench
============================================

# inverse_transmission_srsc

Sequential reciprocal unit that turns an 8-bit transmission estimate t (Q0.8) into the inverse transmission 1/t in Q2.12, the format consumed by the SRSC recovery multiplier. It sits directly upstream of the per-channel (Ic − Ac) × (1/t) multiply. It carries a sideband tag (the three channel differences) so that the tag and the reciprocal leave together. The divide is a radix-2 restoring divider, one quotient bit per cycle, with valid/ready handshakes on both sides.

## Interface
- TAG_W, 24, sideband width carried alongside the value (3 × 8-bit Ic − Ac)
- T_MIN, 64, lower clamp for t (integer Q0.8 code); must satisfy 33 ≤ T_MIN ≤ 255
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  t_in and tag_in are valid
- in_ready  output  1  block can accept; high only in IDLE
- t_in  input  8  transmission, Q0.8 (value = t_in/256)
- tag_in  input  TAG_W  sideband data, latched on accept
- out_valid  output  1  inv_trans and tag_out are valid; held until accepted
- out_ready  input  1  downstream accepts
- inv_trans  output  14  1/t, Q2.12, saturated to 16383
- tag_out  output  TAG_W  tag latched with the accepted input

## Operation
- States: IDLE, DIV, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid, at the clock edge: latch d = max(t_in, T_MIN), latch the tag, set partial remainder r = 32, clear the quotient, set count = 0, and go to DIV.
- **Divide**
  - Computes floor(2^20 / d). The bits of 2^20 above bit 14 equal 32. Because d > 32, the quotient bits above bit 14 are zero, so only quotient bits [14:0] are computed.
  - Each DIV cycle: r' = {r, 0}. If r' ≥ d then r = r' − d and q = {q, 1}; else r = r' and q = {q, 0}. Then count += 1.
  - Width of r: 9 bits is sufficient, since r < d ≤ 255 and so r' < 510.
  - After the 15th iteration (count reaches 14 and is incremented), go to DONE.
- **Result**
  - inv_trans = 16383 when q[14] is set; otherwise q[13:0].
  - Truncating division; no rounding.
- **DONE**
  - out_valid = 1. inv_trans and tag_out are held stable.
  - On out_ready, go to IDLE.
  - in_ready is 0 in DONE.
- t_in values below T_MIN (including 0) are clamped before dividing. No divide-by-zero path exists.
- **Reset**
  - Resets state to IDLE, the quotient, remainder and count to 0, and inv_trans and tag_out to 0.
  - Reset values: out_valid = 0; in_ready = 1 on the first cycle after reset deasserts.
  - A reset mid-divide or in DONE discards the transaction. No output is produced for it.

## Timing
- Accept edge E0: in_valid && in_ready sampled high. State becomes DIV.
- Edges E1..E15: one quotient bit per edge. At E15 the state becomes DONE.
- out_valid is high after E15, giving a latency of 15 clocks from acceptance.
- The handshake completes at the first edge where out_valid && out_ready; the next edge returns the block to IDLE.
- in_ready rises the cycle after the output handshake. Minimum initiation interval is 17 clocks when out_ready is tied high.
- inputs presented while in_ready = 0 are ignored. The upstream stage must hold them.
- Outputs are registered. There is no combinational path from in_* to out_*, or from out_ready to in_ready.
- Backpressure: out_ready may stay low indefinitely. The result and tag must not change during the stall.

## Test plan
- Exact value: t_in = 128, tag = 0xA1B2C3 → inv_trans = 8192 (2.0) and tag_out = 0xA1B2C3. out_valid must rise exactly 15 clocks after the accept edge.
- Truncation: t_in = 255 → 4112; t_in = 200 → 5242; t_in = 100 → 10485.
- Saturation and clamp: t_in = 64 → 16383; t_in = 10 → 16383; t_in = 0 → 16383, with no X on any output.
- Backpressure:
  - Hold out_ready = 0 for 20 cycles after out_valid. Outputs must stay stable and in_ready must stay 0.
  - Release out_ready. Exactly one output handshake must occur, and in_ready must return 1 one cycle later.
- Back-to-back: stream 8 random t_in values with in_valid held high and out_ready = 1. Each result must match floor(2^20 / max(t, T_MIN)) saturated to 16383, in order, with a 17-cycle period.
- Reset mid-operation: assert rst at iteration 7. Next cycle: out_valid = 0, inv_trans = 0, in_ready = 1. A following transaction with t = 128 must complete correctly.

Source files
------------

// File: rtl/inverse_transmission_srsc.sv
`default_nettype none
// ============================================================================
// Module   : inverse_transmission_srsc
// Purpose  : Sequential 1/t reciprocal (Q0.8 in, Q2.12 out) for SRSC recovery,
//            radix-2 restoring divide with a sideband tag carried alongside.
// Revision : 1.0 - initial release
// ============================================================================
module inverse_transmission_srsc #(
  parameter int TAG_W = 24,
  parameter int T_MIN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       t_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [13:0]      inv_trans,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0]  C_T_MIN  = 8'(T_MIN);
  localparam logic [7:0]  C_R_INIT = 8'd32;   // bits of 2^20 above bit 14
  localparam logic [3:0]  C_LAST   = 4'd14;
  localparam logic [13:0] C_SAT    = 14'h3FFF;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_d;
  logic [7:0]  r_rem;
  logic [13:0] r_q;
  logic [3:0]  r_count;

  logic        w_accept;
  logic        w_last;
  logic [8:0]  w_shift;
  logic        w_ge;
  logic [7:0]  w_rem_next;
  logic [14:0] w_q_next;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_last    = (r_state == S_DIV) && (r_count == C_LAST);

  // Remainder stays below d <= 255, so the shifted value fits in 9 bits.
  assign w_shift    = {r_rem, 1'b0};
  assign w_ge       = (w_shift >= {1'b0, r_d});
  assign w_rem_next = w_ge ? 8'(w_shift - {1'b0, r_d}) : w_shift[7:0];
  assign w_q_next   = {r_q, w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_DIV;
      S_DIV:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d       <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_count   <= '0;
      inv_trans <= '0;
      tag_out   <= '0;
    end else if (w_accept) begin
      r_d     <= (t_in < C_T_MIN) ? C_T_MIN : t_in;
      tag_out <= tag_in;
      r_rem   <= C_R_INIT;
      r_q     <= '0;
      r_count <= '0;
    end else if (r_state == S_DIV) begin
      r_rem   <= w_rem_next;
      r_q     <= w_q_next[13:0];
      r_count <= r_count + 4'd1;
      // Quotient bit 14 set means 1/t >= 4.0, outside Q2.12 range.
      if (w_last) begin
        inv_trans <= w_q_next[14] ? C_SAT : w_q_next[13:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inverse_transmission_srsc.sv
`default_nettype none
// ============================================================================
// Module   : tb_inverse_transmission_srsc
// Purpose  : Self-checking bench for inverse_transmission_srsc against an
//            arithmetic reciprocal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inverse_transmission_srsc;

  localparam int TAG_W = 24;
  localparam int T_MIN = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       t_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [13:0]      inv_trans;
  logic [TAG_W-1:0] tag_out;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  inverse_transmission_srsc #(.TAG_W(TAG_W), .T_MIN(T_MIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .t_in      (t_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inv_trans (inv_trans),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  function automatic int ref_inv(input int t);
    int d;
    int q;
    d = (t < T_MIN) ? T_MIN : t;
    q = (1 << 20) / d;
    return (q > 16383) ? 16383 : q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One transaction with latency and result checks; out_ready stays low until out_valid.
  task automatic do_txn(input logic [7:0] t, input logic [TAG_W-1:0] tg, input string nm);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    t_in      = t;
    tag_in    = tg;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin step(); lat++; end
    chk({nm, "_lat"}, lat, 32'd15);
    chk({nm, "_inv"}, {18'd0, inv_trans}, ref_inv(int'(t)));
    chk({nm, "_tag"}, {8'd0, tag_out}, {8'd0, tg});
    out_ready = 1'b1;
    step();
    chk({nm, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [13:0]      q_inv[$];
    logic [TAG_W-1:0] q_tag[$];
    logic [13:0]      snap_inv;
    logic [TAG_W-1:0] snap_tag;
    int bad;
    int w;
    int last_out;
    int n_out;
    int n_acc;
    bit acc;
    bit hs;

    rst = 1'b1; in_valid = 1'b0; t_in = '0; tag_in = '0; out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_inv",       {18'd0, inv_trans}, 32'd0);
    chk("rst_tag",       {8'd0, tag_out},    32'd0);

    do_txn(8'd128, 24'hA1B2C3, "t128");
    do_txn(8'd255, 24'h000001, "t255");
    do_txn(8'd200, 24'h123456, "t200");
    do_txn(8'd100, 24'hFFFFFF, "t100");
    do_txn(8'd64,  24'h0F0F0F, "t64");
    do_txn(8'd10,  24'h555555, "t10");
    do_txn(8'd0,   24'hAAAAAA, "t0");
    chk("t0_noX", {31'd0, ^{inv_trans, tag_out, out_valid, in_ready} === 1'bx}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_txn(8'($urandom_range(0, 255)), TAG_W'($urandom), "rand");
    end

    // Backpressure: stall 20 cycles with a competing input that must be ignored.
    do_txn(8'd255, 24'h010203, "pre_bp");
    in_valid = 1'b1; t_in = 8'd200; tag_in = 24'hBEEF01;
    step();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin step(); w++; end
    chk("bp_inv", {18'd0, inv_trans}, ref_inv(200));
    snap_inv = inv_trans;
    snap_tag = tag_out;
    in_valid = 1'b1; t_in = 8'd5; tag_in = 24'h777777;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          inv_trans !== snap_inv || tag_out !== snap_tag) bad++;
    end
    chk("bp_stall", bad, 32'd0);
    chk("bp_tag", {8'd0, tag_out}, 32'hBEEF01);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid !== 1'b0) bad++;
    end
    chk("bp_single_hs", bad, 32'd0);

    // Back-to-back stream with in_valid held and out_ready tied high.
    last_out = -1; n_out = 0; n_acc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    t_in      = 8'($urandom_range(0, 255));
    tag_in    = TAG_W'($urandom);
    for (int k = 0; k < 8 * 17 + 40 && n_out < 8; k++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        chk("b2b_queued", {31'd0, q_inv.size() > 0}, 32'd1);
        if (q_inv.size() > 0) begin
          chk("b2b_inv", {18'd0, inv_trans}, {18'd0, q_inv.pop_front()});
          chk("b2b_tag", {8'd0, tag_out},    {8'd0, q_tag.pop_front()});
        end
        if (last_out >= 0) chk("b2b_period", cyc - last_out, 32'd17);
        last_out = cyc;
        n_out++;
      end
      if (acc) begin
        q_inv.push_back(14'(ref_inv(int'(t_in))));
        q_tag.push_back(tag_in);
        n_acc++;
      end
      step();
      if (acc) begin
        if (n_acc < 8) begin
          t_in   = 8'($urandom_range(0, 255));
          tag_in = TAG_W'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", n_out, 32'd8);
    out_ready = 1'b0;

    // Reset during iteration 7 discards the transaction.
    in_valid = 1'b1; t_in = 8'd100; tag_in = 24'h0BAD00;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_inv",       {18'd0, inv_trans}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    do_txn(8'd128, 24'hC0FFEE, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
